// File: rtl/msg_sender_pkg.sv
// msg_sender_pkg
// Shared definitions for the message sender: controller state encoding,
// UART frame geometry and the bit-period divider calculation.
package msg_sender_pkg;

    // Message controller states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } sender_state_e;

    // 8N1 frame: start + 8 data + stop.
    localparam int unsigned FRAME_BITS = 10;

    // Clock cycles per serial bit, rounded to the nearest integer.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + (baud / 32'd2)) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core
// Bit-level 8N1 transmitter. A byte presented on data with load high while
// ready is high is sent as start(0), data LSB first, stop(1); each bit lasts
// DIV clk12 cycles. ready rises on the edge that ends the stop bit.
// Ports:
//   clk12 - clock, rising edge
//   rst   - asynchronous active-high reset (tx forced high)
//   data  - byte to send, sampled with load
//   load  - start a frame (ignored while a frame is in flight)
//   tx    - serial output, idle high
//   ready - high when no frame is in flight
module uart_tx_core
    import msg_sender_pkg::*;
#(
    parameter int unsigned DIV = 104
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic       tx,
    output logic       ready
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'(FRAME_BITS - 1);

    logic [8:0]  shift_r;
    logic [15:0] div_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic        active_r;
    logic        tx_r;
    logic        ready_r;

    // Frame sequencer: the start bit is driven directly at load, the shift
    // register then holds {stop, data} and feeds one bit per bit period.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            shift_r   <= 9'h1FF;
            div_cnt_r <= 16'd0;
            bit_cnt_r <= 4'd0;
            active_r  <= 1'b0;
            tx_r      <= 1'b1;
            ready_r   <= 1'b1;
        end else if (!active_r) begin
            if (load) begin
                shift_r   <= {1'b1, data};
                tx_r      <= 1'b0;
                active_r  <= 1'b1;
                ready_r   <= 1'b0;
                div_cnt_r <= 16'd0;
                bit_cnt_r <= 4'd0;
            end else begin
                tx_r    <= 1'b1;
                ready_r <= 1'b1;
            end
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= 16'd0;
            if (bit_cnt_r == LAST_BIT) begin
                active_r <= 1'b0;
                ready_r  <= 1'b1;
                tx_r     <= 1'b1;
            end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
                tx_r      <= shift_r[0];
                shift_r   <= {1'b1, shift_r[8:1]};
            end
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    assign tx    = tx_r;
    assign ready = ready_r;

endmodule

// File: rtl/msg_uart_sender.sv
// msg_uart_sender
// Sends a fixed ASCII message over a UART when triggered by a button press
// (falling edge of the synchronised key_n) or a start pulse. Optional early
// stop on TERM_CHAR (the terminator itself is sent).
// Build option: define MSG_SENDER_REPEAT_EN to add input repeat_msg; while it
// is high a finished message restarts from its first byte without dropping
// busy. (The port cannot be called "repeat": that is a reserved word.)
// Ports:
//   clk12    - clock, rising edge
//   rst      - asynchronous active-high reset
//   key_n    - raw button, idle high
//   start    - synchronous one-cycle trigger
//   tx       - UART TxD, 8N1, idle high
//   busy     - high from accepted trigger until the last stop bit ends
//   done     - one-cycle pulse per completed message
//   sent_cnt - completed message count, wraps
module msg_uart_sender
    import msg_sender_pkg::*;
#(
    parameter int unsigned          CLK_HZ    = 12_000_000,
    parameter int unsigned          BAUD      = 115_200,
    parameter int unsigned          MSG_LEN   = 16,
    parameter logic [8*MSG_LEN-1:0] MESSAGE   = "Hello World!\r\n  ",
    parameter logic [7:0]           TERM_CHAR = 8'h00
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic       key_n,
    input  logic       start,
`ifdef MSG_SENDER_REPEAT_EN
    input  logic       repeat_msg,
`endif
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [7:0] sent_cnt
);

    localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
    localparam logic [7:0]  LAST_IDX = 8'(MSG_LEN - 1);

    sender_state_e state_r;
    sender_state_e state_nx_s;
    logic [7:0]    idx_r;
    logic [7:0]    idx_nx_s;
    logic          key_meta_r;
    logic          key_sync_r;
    logic          key_prev_r;
    logic [2:0]    fill_r;
    logic          trig_s;
    logic          rep_s;
    logic          last_s;
    logic          busy_nx_s;
    logic          load_s;
    logic          tx_ready_s;
    logic [7:0]    byte_s;
    logic          busy_r;
    logic          done_r;
    logic [7:0]    cnt_r;
    logic [7:0]    msg_mem_s [256];

    // Message ROM, leftmost character at index 0; unused slots read as 0.
    for (genvar g = 0; g < 256; g++) begin : g_rom
        if (g < MSG_LEN) begin : g_used
            assign msg_mem_s[g] = MESSAGE[8*(MSG_LEN-1-g) +: 8];
        end else begin : g_pad
            assign msg_mem_s[g] = 8'h00;
        end
    end

    assign byte_s = msg_mem_s[idx_r];

`ifdef MSG_SENDER_REPEAT_EN
    assign rep_s = repeat_msg;
`else
    assign rep_s = 1'b0;
`endif

    // Key synchroniser plus edge history. fill_r keeps edge detection off
    // until every stage holds a real sample, so a key already held low
    // through reset does not look like a fresh press.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            key_meta_r <= 1'b1;
            key_sync_r <= 1'b1;
            key_prev_r <= 1'b1;
            fill_r     <= 3'b000;
        end else begin
            key_meta_r <= key_n;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
            fill_r     <= {fill_r[1:0], 1'b1};
        end
    end

    assign trig_s = start | (fill_r[2] & key_prev_r & ~key_sync_r);
    assign last_s = (idx_r == LAST_IDX) ||
                    ((TERM_CHAR != 8'h00) && (byte_s == TERM_CHAR));
    assign load_s = (state_r == S_LOAD);

    // Next-state logic. WAIT -> LOAD plus the LOAD cycle itself give the two
    // idle tx cycles between characters of one message.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        case (state_r)
            S_IDLE: begin
                if (trig_s) begin
                    state_nx_s = S_LOAD;
                    idx_nx_s   = 8'd0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LOAD: state_nx_s = S_SEND;
            S_SEND: begin
                if (!tx_ready_s) begin
                    state_nx_s = S_WAIT;
                end else begin
                    state_nx_s = S_SEND;
                end
            end
            S_WAIT: begin
                if (!tx_ready_s) begin
                    state_nx_s = S_WAIT;
                end else if (last_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_LOAD;
                    idx_nx_s   = idx_r + 8'd1;
                end
            end
            S_DONE: begin
                if (rep_s) begin
                    state_nx_s = S_LOAD;
                    idx_nx_s   = 8'd0;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
                idx_nx_s   = 8'd0;
            end
        endcase
    end

    // busy drops on entry to DONE unless the message is about to restart.
    always_comb begin
        busy_nx_s = 1'b0;
        if (state_nx_s == S_IDLE) begin
            busy_nx_s = 1'b0;
        end else if (state_nx_s == S_DONE) begin
            busy_nx_s = rep_s;
        end else begin
            busy_nx_s = 1'b1;
        end
    end

    // State, index and registered status outputs.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            idx_r   <= 8'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= (state_nx_s == S_DONE);
            if (state_nx_s == S_DONE) begin
                cnt_r <= cnt_r + 8'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    uart_tx_core #(
        .DIV (DIV)
    ) u_tx (
        .clk12 (clk12),
        .rst   (rst),
        .data  (byte_s),
        .load  (load_s),
        .tx    (tx),
        .ready (tx_ready_s)
    );

    assign busy     = busy_r;
    assign done     = done_r;
    assign sent_cnt = cnt_r;

endmodule

// File: tb/tb_msg_uart_sender.sv
// Testbench for msg_uart_sender: two instances ("Hi" without terminator and
// "ab*cd" with '*' as terminator) at 12 MHz / 1 Mbaud (12 cycles per bit).
// A UART receiver and a done/busy monitor check against queues filled by a
// message-level model when triggers are issued.
module tb_msg_uart_sender;

    localparam int unsigned CLK_HZ = 12_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int BIT_T  = 12;
    localparam int CHAR_T = 10 * BIT_T + 2;

    typedef struct {
        int busy_done;
        int len;
        int cnt;
    } rec_t;

    logic       clk12 = 1'b0;
    logic       rst   = 1'b1;
    logic [1:0] key_v   = 2'b11;
    logic [1:0] start_v = 2'b00;
    logic [1:0] tx_v;
    logic [1:0] busy_v;
    logic [1:0] done_v;
    logic [7:0] cnt_v [2];
`ifdef MSG_SENDER_REPEAT_EN
    logic       rep0 = 1'b0;
`endif

    int         edge_n = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         rst_epoch = 0;
    int         free_at [2];
    int         exp_cnt [2];
    int         last_t0 [2];
    int         last_ep [2];
    int         run [2];
    int         last_run [2];
    string      msgs [2];
    logic [7:0] term [2];
    logic [8:0] exp_q [2][$];
    rec_t       rec_q [2][$];

    always #5 clk12 = ~clk12;
    always @(posedge clk12) edge_n <= edge_n + 1;

    msg_uart_sender #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MSG_LEN(2), .MESSAGE("Hi"), .TERM_CHAR(8'h00)
    ) dut0 (
        .clk12(clk12), .rst(rst), .key_n(key_v[0]), .start(start_v[0]),
`ifdef MSG_SENDER_REPEAT_EN
        .repeat_msg(rep0),
`endif
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sent_cnt(cnt_v[0])
    );

    msg_uart_sender #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MSG_LEN(5), .MESSAGE("ab*cd"), .TERM_CHAR(8'h2A)
    ) dut1 (
        .clk12(clk12), .rst(rst), .key_n(key_v[1]), .start(start_v[1]),
`ifdef MSG_SENDER_REPEAT_EN
        .repeat_msg(1'b0),
`endif
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sent_cnt(cnt_v[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at edge %0d",
                     nm, act, act, exp, exp, edge_n);
        end
    endtask

    task automatic fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s at edge %0d", nm, edge_n);
    endtask

    // Issue one trigger and let the model decide whether it is accepted.
    task automatic trig(input int u, input bit use_key, input int hold, input int reps);
        int k, a, n, blen;
        string m;
        @(negedge clk12);
        k = edge_n + 1;
        if (use_key) begin
            key_v[u] = 1'b0;
            a = k + 2;
        end else begin
            start_v[u] = 1'b1;
            a = k;
        end
        if (a >= free_at[u]) begin
            m = msgs[u];
            n = 0;
            for (int i = 0; i < m.len(); i++) begin
                n++;
                if (term[u] != 8'h00 && m[i] == term[u]) break;
            end
            blen = (reps - 1) * (n * CHAR_T + 1) + n * CHAR_T;
            for (int r = 0; r < reps; r++) begin
                for (int i = 0; i < n; i++) exp_q[u].push_back({1'(i == 0), 8'(m[i])});
                exp_cnt[u] = (exp_cnt[u] + 1) % 256;
                rec_q[u].push_back('{busy_done: (r < reps - 1) ? 1 : 0,
                                     len: (r == reps - 1) ? blen : 0,
                                     cnt: exp_cnt[u]});
            end
            free_at[u] = a + blen + 2;
        end
        @(negedge clk12);
        start_v[u] = 1'b0;
        if (use_key) begin
            repeat (hold) @(negedge clk12);
            key_v[u] = 1'b1;
            repeat (3) @(negedge clk12);
        end
    endtask

    task automatic drain();
        int m;
        m = (free_at[0] > free_at[1]) ? free_at[0] : free_at[1];
        while (edge_n < m + 10) @(negedge clk12);
    endtask

    // UART receiver: mid-bit sampling; frames cut by reset are discarded.
    task automatic rx_frame(input int u);
        int t0, ep;
        logic s0, s9;
        logic [7:0] b;
        logic [8:0] e;
        do begin
            @(posedge clk12); #1;
        end while (tx_v[u] !== 1'b0);
        t0 = edge_n;
        ep = rst_epoch;
        repeat (BIT_T / 2) @(posedge clk12);
        #1 s0 = tx_v[u];
        for (int j = 0; j < 8; j++) begin
            repeat (BIT_T) @(posedge clk12);
            #1 b[j] = tx_v[u];
        end
        repeat (BIT_T) @(posedge clk12);
        #1 s9 = tx_v[u];
        if (ep == rst_epoch) begin
            chk("start_bit", int'(s0), 0);
            chk("stop_bit", int'(s9), 1);
            if (exp_q[u].size() == 0) begin
                fail($sformatf("unexpected_char u%0d 0x%0h", u, b));
            end else begin
                e = exp_q[u].pop_front();
                chk($sformatf("char_u%0d", u), int'(b), int'(e[7:0]));
                if (!e[8] && last_ep[u] == ep) chk("char_spacing", t0 - last_t0[u], CHAR_T);
            end
            last_t0[u] = t0;
            last_ep[u] = ep;
        end
    endtask

    initial forever rx_frame(0);
    initial forever rx_frame(1);

    // done/busy monitor: busy run length, busy at done and sent_cnt per message.
    always @(negedge clk12) begin
        rec_t r;
        for (int u = 0; u < 2; u++) begin
            if (busy_v[u] === 1'b1) begin
                run[u]++;
            end else if (run[u] != 0) begin
                last_run[u] = run[u];
                run[u] = 0;
            end
            if (done_v[u] === 1'b1) begin
                if (rec_q[u].size() == 0) begin
                    fail($sformatf("unexpected_done u%0d", u));
                end else begin
                    r = rec_q[u].pop_front();
                    chk("busy_at_done", int'(busy_v[u]), r.busy_done);
                    chk("sent_cnt", int'(cnt_v[u]), r.cnt);
                    if (r.len > 0) chk("busy_length", last_run[u], r.len);
                end
            end
        end
    end

    initial begin
        int seen;
        msgs[0] = "Hi";
        msgs[1] = "ab*cd";
        term[0] = 8'h00;
        term[1] = 8'h2A;
        for (int u = 0; u < 2; u++) begin
            free_at[u] = 0; exp_cnt[u] = 0; last_t0[u] = 0; last_ep[u] = -1;
            run[u] = 0; last_run[u] = 0;
        end

        // Reset values.
        repeat (3) @(negedge clk12);
        for (int u = 0; u < 2; u++) begin
            chk("rst_tx", int'(tx_v[u]), 1);
            chk("rst_busy", int'(busy_v[u]), 0);
            chk("rst_done", int'(done_v[u]), 0);
            chk("rst_cnt", int'(cnt_v[u]), 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk12);

        // "Hi" by start, then an exactly back-to-back trigger.
        trig(0, 1'b0, 0, 1);
        while (edge_n + 2 < free_at[0]) @(negedge clk12);
        trig(0, 1'b0, 0, 1);
        // Retrigger about 50 cycles into the message: must be ignored.
        repeat (48) @(negedge clk12);
        trig(0, 1'b0, 0, 1);
        drain();

        // Early stop on the terminator.
        trig(1, 1'b0, 0, 1);
        drain();

        // Key held low for 1000 cycles: one message only.
        trig(0, 1'b1, 1000, 1);
        drain();

        // Random triggers on both instances, by key or start, some while busy.
        for (int i = 0; i < 16; i++) begin
            trig(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(2, 20)), 1);
            repeat ($urandom_range(0, 300)) @(negedge clk12);
        end
        drain();

        // Reset 60 cycles into the first character.
        trig(0, 1'b0, 0, 1);
        repeat (61) @(negedge clk12);
        rst_epoch++;
        for (int u = 0; u < 2; u++) begin
            exp_q[u].delete(); rec_q[u].delete();
            exp_cnt[u] = 0; free_at[u] = 0;
        end
        rst = 1'b1;
        #1;
        chk("abort_tx", int'(tx_v[0]), 1);
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_cnt", int'(cnt_v[0]), 0);
        repeat (3) @(negedge clk12);
        rst = 1'b0;
        repeat (100) @(negedge clk12);
        chk("post_rst_busy0", int'(busy_v[0]), 0);
        chk("post_rst_busy1", int'(busy_v[1]), 0);

`ifdef MSG_SENDER_REPEAT_EN
        // Continuous resend for three messages.
        rep0 = 1'b1;
        trig(0, 1'b0, 0, 3);
        seen = 0;
        for (int c = 0; c < 1200 && seen < 2; c++) begin
            @(negedge clk12);
            if (done_v[0] === 1'b1) seen++;
        end
        rep0 = 1'b0;
        chk("repeat_done_wait", seen, 2);
        drain();
`else
        seen = 0;
`endif

        for (int u = 0; u < 2; u++) begin
            chk("chars_outstanding", exp_q[u].size(), 0);
            chk("done_outstanding", rec_q[u].size(), 0);
            chk("final_cnt", int'(cnt_v[u]), exp_cnt[u]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
